branch_resolve_unit: RTL and testbench
======================================

BRANCH_RESOLVE_UNIT -- requirements
Module: branch_resolve_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32: data, offset and PC width in bits.
REQ-002 SHALL have parameter RAS_DEPTH, default 4: return-address-stack entries, a power of two and at least 2.
REQ-003 SHALL have parameter SIGNED_CMP, default 0: 0 = unsigned compares, 1 = two's-complement compares.
REQ-004 SHALL have port clk, input, 1 bit: the single clock.
REQ-005 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port in_valid, input, 1 bit: the request is valid.
REQ-007 SHALL have port in_ready, output, 1 bit: the unit accepts the request this cycle.
REQ-008 SHALL have port instr_ID, input, 32 bits: the decoded instruction ID.
REQ-009 SHALL have ports pc, rs, rt, rd, input, WIDTH bits each: current PC, operand 1, operand 2, branch offset.
REQ-010 SHALL have port out_valid, output, 1 bit: the result is valid.
REQ-011 SHALL have port out_ready, input, 1 bit: the consumer accepts the result.
REQ-012 SHALL have port is_branch, output, 1 bit: the accepted ID was in 15..23.
REQ-013 SHALL have port taken, output, 1 bit: control flow redirected.
REQ-014 SHALL have port next_pc, output, WIDTH bits: the resolved next PC.
REQ-015 SHALL have port link_we and port link_data, outputs, 1 and WIDTH bits: jal link write enable and value.
REQ-016 SHALL have port ras_pred, output, WIDTH bits: the RAS-predicted target for jr.
REQ-017 SHALL have port ras_mispredict, output, 1 bit: ras_pred differs from rs on jr.
REQ-018 SHALL have port ras_empty and port ras_full, outputs, 1 bit each: RAS status.

Function
REQ-019 SHALL accept a request when in_valid && in_ready, with in_ready = !out_valid || out_ready (combinational).
REQ-020 SHALL register every result output one cycle after acceptance, with out_valid=1.
REQ-021 SHALL hold all result outputs stable while out_valid && !out_ready.
REQ-022 SHALL clear out_valid after a handshake when no new request is accepted in the same cycle; an accept in that cycle reloads out_valid to 1 (back-to-back throughput of 1 per cycle).
REQ-023 SHALL use these IDs: 15 beq (==), 16 bne (!=), 17 bgt (>), 18 bgte (>=), 19 ble (<), 20 bleq (<=), each comparing rs against rt.
REQ-024 SHALL perform the compares of REQ-023 signed when SIGNED_CMP=1 and unsigned when SIGNED_CMP=0.
REQ-025 SHALL, for a conditional branch, set taken to the compare result and next_pc = taken ? pc+rd : pc+1, modulo 2^WIDTH.
REQ-026 SHALL, for IDs 21 j, 22 jr and 23 jal, set taken=1 and next_pc=rs.
REQ-027 SHALL, for jal, set link_we=1 and link_data=pc+1, and push pc+1 onto the RAS.
REQ-028 SHALL, when the RAS is full on a push, overwrite the oldest entry (circular wrap) and keep ras_full=1.
REQ-029 SHALL, for jr with the RAS not empty, set ras_pred to the top entry, pop it, and set ras_mispredict = (ras_pred != rs).
REQ-030 SHALL, for jr with the RAS empty, set ras_pred=0 and ras_mispredict=0, and leave the pointer unchanged (no underflow).
REQ-031 SHALL, for any ID outside 15..23, set is_branch=0, taken=0 and next_pc=pc+1, and leave the RAS unchanged.
REQ-032 SHALL set link_we=0, ras_pred=0 and ras_mispredict=0 for every non-jal/non-jr result.
REQ-033 SHALL update the RAS only on acceptance, never during a stall.
REQ-034 SHALL present ras_empty and ras_full from registered occupancy, reflecting accepted pushes and pops from the following cycle.

Reset
REQ-035 SHALL, on reset, clear out_valid, is_branch, taken, next_pc, link_we, link_data, ras_pred and ras_mispredict to 0.
REQ-036 SHALL, on reset, empty the RAS: ras_empty=1, ras_full=0.
REQ-037 SHALL let reset override an in-flight or stalled result, discarding that result.
REQ-038 SHALL hold in_ready=1 during reset; no request is accepted while reset=1.

Verification
REQ-039 SHALL cover: SIGNED_CMP=0, bgt with rs=0xFFFFFFFF, rt=1, pc=100, rd=10 -> taken=1, next_pc=110, one cycle later. With SIGNED_CMP=1 and the same stimulus -> taken=0, next_pc=101.
REQ-040 SHALL cover: jal at pc=40 with rs=200 -> next_pc=200, link_we=1, link_data=41. Then jr with rs=41 -> ras_pred=41, ras_mispredict=0, ras_empty=1.
REQ-041 SHALL cover: RAS_DEPTH=4, jal at pc=0,10,20,30,40 -> ras_full=1. Then five jr -> preds 41,31,21,11, then a fifth jr with ras_pred=0.
REQ-042 SHALL cover: out_ready=0 for 3 cycles with in_valid=1 -> outputs frozen, in_ready=0, no RAS change. On release, in-order results with no loss or duplication.
REQ-043 SHALL cover: instr_ID=5 with pc=0xFFFFFFFF -> is_branch=0, next_pc=0 (wrap).
REQ-044 SHALL cover: reset asserted while a jal result is stalled -> out_valid=0 and ras_empty=1 in the next cycle.

Source files
------------

// File: rtl/branch_resolve_unit.sv
// Branch resolution stage with a small return-address stack.
// Resolves conditional branches, j/jr/jal, produces link writes for jal and
// predicts jr targets from a circular RAS. One request per cycle through a
// single valid/ready output register.
module branch_resolve_unit #(
  parameter int WIDTH      = 32,
  parameter int RAS_DEPTH  = 4,
  parameter int SIGNED_CMP = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      instr_ID,
  input  logic [WIDTH-1:0] pc,
  input  logic [WIDTH-1:0] rs,
  input  logic [WIDTH-1:0] rt,
  input  logic [WIDTH-1:0] rd,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             is_branch,
  output logic             taken,
  output logic [WIDTH-1:0] next_pc,
  output logic             link_we,
  output logic [WIDTH-1:0] link_data,
  output logic [WIDTH-1:0] ras_pred,
  output logic             ras_mispredict,
  output logic             ras_empty,
  output logic             ras_full
);

  localparam int PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(RAS_DEPTH);
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  localparam logic [31:0] ID_BEQ  = 32'd15;
  localparam logic [31:0] ID_BNE  = 32'd16;
  localparam logic [31:0] ID_BGT  = 32'd17;
  localparam logic [31:0] ID_BGTE = 32'd18;
  localparam logic [31:0] ID_BLE  = 32'd19;
  localparam logic [31:0] ID_BLEQ = 32'd20;
  localparam logic [31:0] ID_J    = 32'd21;
  localparam logic [31:0] ID_JR   = 32'd22;
  localparam logic [31:0] ID_JAL  = 32'd23;

  // output register
  logic             out_valid_q, out_valid_d;
  logic             is_branch_q, is_branch_d;
  logic             taken_q, taken_d;
  logic [WIDTH-1:0] next_pc_q, next_pc_d;
  logic             link_we_q, link_we_d;
  logic [WIDTH-1:0] link_data_q, link_data_d;
  logic [WIDTH-1:0] ras_pred_q, ras_pred_d;
  logic             ras_mispredict_q, ras_mispredict_d;

  // return-address stack: sp points at the top entry, cnt is occupancy
  logic [WIDTH-1:0] ras_mem_q [RAS_DEPTH];
  logic [WIDTH-1:0] ras_mem_d [RAS_DEPTH];
  logic [PTR_W-1:0] ras_sp_q, ras_sp_d;
  logic [CNT_W-1:0] ras_cnt_q, ras_cnt_d;

  logic             accept;
  logic             cmp_eq, cmp_lt, cmp_res;
  logic             res_is_branch, res_taken, res_link_we, res_mispredict;
  logic [WIDTH-1:0] res_next_pc, res_link_data, res_pred;
  logic             ras_push, ras_pop;
  logic [WIDTH-1:0] pc_plus_one;

  // Handshake; reset forces ready high but nothing is accepted during it.
  always_comb begin
    in_ready = reset | ~out_valid_q | out_ready;
    accept   = in_valid & in_ready & ~reset;
  end

  // Operand comparison, signedness fixed by parameter.
  always_comb begin
    cmp_eq = (rs == rt);
    if (SIGNED_CMP != 0) begin
      cmp_lt = ($signed(rs) < $signed(rt));
    end else begin
      cmp_lt = (rs < rt);
    end
  end

  // Decode and resolve the presented request, including RAS actions.
  always_comb begin
    pc_plus_one    = pc + ONE;
    cmp_res        = 1'b0;
    res_is_branch  = 1'b0;
    res_taken      = 1'b0;
    res_next_pc    = pc_plus_one;
    res_link_we    = 1'b0;
    res_link_data  = '0;
    res_pred       = '0;
    res_mispredict = 1'b0;
    ras_push       = 1'b0;
    ras_pop        = 1'b0;
    case (instr_ID)
      ID_BEQ:  cmp_res = cmp_eq;
      ID_BNE:  cmp_res = ~cmp_eq;
      ID_BGT:  cmp_res = ~cmp_lt & ~cmp_eq;
      ID_BGTE: cmp_res = ~cmp_lt;
      ID_BLE:  cmp_res = cmp_lt;
      ID_BLEQ: cmp_res = cmp_lt | cmp_eq;
      default: cmp_res = 1'b0;
    endcase
    case (instr_ID)
      ID_BEQ, ID_BNE, ID_BGT, ID_BGTE, ID_BLE, ID_BLEQ: begin
        res_is_branch = 1'b1;
        res_taken     = cmp_res;
        res_next_pc   = cmp_res ? (pc + rd) : pc_plus_one;
      end
      ID_J: begin
        res_is_branch = 1'b1;
        res_taken     = 1'b1;
        res_next_pc   = rs;
      end
      ID_JR: begin
        res_is_branch = 1'b1;
        res_taken     = 1'b1;
        res_next_pc   = rs;
        if (ras_cnt_q != '0) begin
          res_pred       = ras_mem_q[ras_sp_q];
          res_mispredict = (ras_mem_q[ras_sp_q] != rs);
          ras_pop        = 1'b1;
        end
      end
      ID_JAL: begin
        res_is_branch = 1'b1;
        res_taken     = 1'b1;
        res_next_pc   = rs;
        res_link_we   = 1'b1;
        res_link_data = pc_plus_one;
        ras_push      = 1'b1;
      end
      default: begin
        res_is_branch = 1'b0;
      end
    endcase
  end

  // RAS update on acceptance only; a push into a full stack overwrites the
  // oldest entry because the top pointer simply wraps onto it.
  always_comb begin
    for (int i = 0; i < RAS_DEPTH; i++) begin
      ras_mem_d[i] = ras_mem_q[i];
    end
    ras_sp_d  = ras_sp_q;
    ras_cnt_d = ras_cnt_q;
    if (accept && ras_push) begin
      ras_sp_d            = ras_sp_q + PTR_W'(1);
      ras_mem_d[ras_sp_d] = pc_plus_one;
      if (ras_cnt_q != CNT_FULL) begin
        ras_cnt_d = ras_cnt_q + CNT_W'(1);
      end
    end else if (accept && ras_pop) begin
      ras_sp_d  = ras_sp_q - PTR_W'(1);
      ras_cnt_d = ras_cnt_q - CNT_W'(1);
    end
  end

  // Output register: load on accept, hold while stalled, drop valid after handshake.
  always_comb begin
    out_valid_d      = out_valid_q;
    is_branch_d      = is_branch_q;
    taken_d          = taken_q;
    next_pc_d        = next_pc_q;
    link_we_d        = link_we_q;
    link_data_d      = link_data_q;
    ras_pred_d       = ras_pred_q;
    ras_mispredict_d = ras_mispredict_q;
    if (accept) begin
      out_valid_d      = 1'b1;
      is_branch_d      = res_is_branch;
      taken_d          = res_taken;
      next_pc_d        = res_next_pc;
      link_we_d        = res_link_we;
      link_data_d      = res_link_data;
      ras_pred_d       = res_pred;
      ras_mispredict_d = res_mispredict;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q      <= 1'b0;
      is_branch_q      <= 1'b0;
      taken_q          <= 1'b0;
      next_pc_q        <= '0;
      link_we_q        <= 1'b0;
      link_data_q      <= '0;
      ras_pred_q       <= '0;
      ras_mispredict_q <= 1'b0;
      ras_sp_q         <= '0;
      ras_cnt_q        <= '0;
      for (int i = 0; i < RAS_DEPTH; i++) begin
        ras_mem_q[i] <= '0;
      end
    end else begin
      out_valid_q      <= out_valid_d;
      is_branch_q      <= is_branch_d;
      taken_q          <= taken_d;
      next_pc_q        <= next_pc_d;
      link_we_q        <= link_we_d;
      link_data_q      <= link_data_d;
      ras_pred_q       <= ras_pred_d;
      ras_mispredict_q <= ras_mispredict_d;
      ras_sp_q         <= ras_sp_d;
      ras_cnt_q        <= ras_cnt_d;
      for (int i = 0; i < RAS_DEPTH; i++) begin
        ras_mem_q[i] <= ras_mem_d[i];
      end
    end
  end

  // Drive ports from registered state.
  always_comb begin
    out_valid      = out_valid_q;
    is_branch      = is_branch_q;
    taken          = taken_q;
    next_pc        = next_pc_q;
    link_we        = link_we_q;
    link_data      = link_data_q;
    ras_pred       = ras_pred_q;
    ras_mispredict = ras_mispredict_q;
    ras_empty      = (ras_cnt_q == '0);
    ras_full       = (ras_cnt_q == CNT_FULL);
  end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Bench for branch_resolve_unit: an unsigned and a signed instance share
// stimulus; expectations come from a queue-based RAS model and plain compares.
module tb_branch_resolve_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        out_ready;
  logic [31:0] instr_ID, pc, rs, rt, rd;

  logic        u_in_ready, u_out_valid, u_is_branch, u_taken, u_link_we;
  logic        u_ras_mispredict, u_ras_empty, u_ras_full;
  logic [31:0] u_next_pc, u_link_data, u_ras_pred;
  logic        s_in_ready, s_out_valid, s_is_branch, s_taken, s_link_we;
  logic        s_ras_mispredict, s_ras_empty, s_ras_full;
  logic [31:0] s_next_pc, s_link_data, s_ras_pred;

  int checks   = 0;
  int failures = 0;

  logic [31:0] ras_m[$];

  always #5 clk = ~clk;

  branch_resolve_unit #(.WIDTH(32), .RAS_DEPTH(4), .SIGNED_CMP(0)) dut_u (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(u_in_ready),
    .instr_ID(instr_ID), .pc(pc), .rs(rs), .rt(rt), .rd(rd),
    .out_valid(u_out_valid), .out_ready(out_ready), .is_branch(u_is_branch),
    .taken(u_taken), .next_pc(u_next_pc), .link_we(u_link_we),
    .link_data(u_link_data), .ras_pred(u_ras_pred),
    .ras_mispredict(u_ras_mispredict), .ras_empty(u_ras_empty), .ras_full(u_ras_full)
  );

  branch_resolve_unit #(.WIDTH(32), .RAS_DEPTH(4), .SIGNED_CMP(1)) dut_s (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(s_in_ready),
    .instr_ID(instr_ID), .pc(pc), .rs(rs), .rt(rt), .rd(rd),
    .out_valid(s_out_valid), .out_ready(out_ready), .is_branch(s_is_branch),
    .taken(s_taken), .next_pc(s_next_pc), .link_we(s_link_we),
    .link_data(s_link_data), .ras_pred(s_ras_pred),
    .ras_mispredict(s_ras_mispredict), .ras_empty(s_ras_empty), .ras_full(s_ras_full)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic bit cond(input logic [31:0] id, input logic [31:0] a,
                              input logic [31:0] b, input bit sgn);
    longint x, y;
    if (sgn) begin
      x = longint'($signed(a));
      y = longint'($signed(b));
    end else begin
      x = longint'({32'd0, a});
      y = longint'({32'd0, b});
    end
    case (id)
      32'd15:  return x == y;
      32'd16:  return x != y;
      32'd17:  return x > y;
      32'd18:  return x >= y;
      32'd19:  return x < y;
      32'd20:  return x <= y;
      default: return 1'b0;
    endcase
  endfunction

  // One accepted request with out_ready=1, checked one cycle later.
  task automatic issue(input logic [31:0] id, input logic [31:0] p, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] off);
    bit br, isj, jal, jr, tk_u, tk_s, mis;
    logic [31:0] npc_u, npc_s, pred;
    br  = (id >= 15) && (id <= 23);
    isj = (id >= 21) && (id <= 23);
    jal = (id == 23);
    jr  = (id == 22);
    tk_u = isj ? 1'b1 : (br ? cond(id, a, b, 1'b0) : 1'b0);
    tk_s = isj ? 1'b1 : (br ? cond(id, a, b, 1'b1) : 1'b0);
    npc_u = isj ? a : (tk_u ? p + off : p + 32'd1);
    npc_s = isj ? a : (tk_s ? p + off : p + 32'd1);
    pred = 32'd0;
    mis  = 1'b0;
    if (jr && ras_m.size() > 0) begin
      pred = ras_m[$];
      mis  = (pred != a);
      void'(ras_m.pop_back());
    end
    if (jal) begin
      ras_m.push_back(p + 32'd1);
      if (ras_m.size() > 4) void'(ras_m.pop_front());
    end
    instr_ID = id; pc = p; rs = a; rt = b; rd = off;
    in_valid = 1'b1;
    #1;
    chk("in_ready", {31'd0, u_in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("out_valid", {31'd0, u_out_valid}, 32'd1);
    chk("is_branch", {31'd0, u_is_branch}, {31'd0, br});
    chk("taken_u", {31'd0, u_taken}, {31'd0, tk_u});
    chk("next_pc_u", u_next_pc, npc_u);
    chk("taken_s", {31'd0, s_taken}, {31'd0, tk_s});
    chk("next_pc_s", s_next_pc, npc_s);
    chk("link_we", {31'd0, u_link_we}, {31'd0, jal});
    if (jal) chk("link_data", u_link_data, p + 32'd1);
    chk("ras_pred", u_ras_pred, pred);
    chk("ras_mispredict", {31'd0, u_ras_mispredict}, {31'd0, mis});
    chk("ras_empty", {31'd0, u_ras_empty}, {31'd0, ras_m.size() == 0});
    chk("ras_full", {31'd0, u_ras_full}, {31'd0, ras_m.size() == 4});
  endtask

  initial begin
    logic [31:0] id, a, b, p, off;
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    instr_ID = 0; pc = 0; rs = 0; rt = 0; rd = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", {31'd0, u_out_valid}, 32'd0);
    chk("rst_next_pc", u_next_pc, 32'd0);
    chk("rst_taken", {31'd0, u_taken}, 32'd0);
    chk("rst_link_data", u_link_data, 32'd0);
    chk("rst_ras_empty", {31'd0, u_ras_empty}, 32'd1);
    chk("rst_ras_full", {31'd0, u_ras_full}, 32'd0);
    chk("rst_in_ready", {31'd0, u_in_ready}, 32'd1);
    reset = 1'b0;
    @(posedge clk); #1;

    // bgt signedness example
    issue(32'd17, 32'd100, 32'hFFFF_FFFF, 32'd1, 32'd10);
    chk("ex_bgt_u_npc", u_next_pc, 32'd110);
    chk("ex_bgt_s_npc", s_next_pc, 32'd101);

    // valid drops after handshake with no new request
    @(posedge clk); #1;
    chk("valid_drop", {31'd0, u_out_valid}, 32'd0);

    // jal then matching jr
    issue(32'd23, 32'd40, 32'd200, 32'd0, 32'd0);
    chk("ex_jal_link", u_link_data, 32'd41);
    issue(32'd22, 32'd7, 32'd41, 32'd0, 32'd0);
    chk("ex_jr_pred", u_ras_pred, 32'd41);

    // overflow wrap: five pushes, five pops
    for (int i = 0; i < 5; i++) issue(32'd23, 32'(i * 10), 32'd500, 32'd0, 32'd0);
    chk("ex_full", {31'd0, u_ras_full}, 32'd1);
    for (int i = 0; i < 5; i++) issue(32'd22, 32'd3, 32'd11, 32'd0, 32'd0);
    chk("ex_last_pred", u_ras_pred, 32'd0);

    // non-branch with PC wrap
    issue(32'd5, 32'hFFFF_FFFF, 32'd9, 32'd9, 32'd9);
    chk("ex_wrap_npc", u_next_pc, 32'd0);

    // stall: j result held three cycles while a jal waits
    issue(32'd21, 32'd5, 32'd77, 32'd0, 32'd0);
    out_ready = 1'b0;
    instr_ID = 32'd23; pc = 32'd60; rs = 32'd300; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("stall_in_ready", {31'd0, u_in_ready}, 32'd0);
      chk("stall_valid", {31'd0, u_out_valid}, 32'd1);
      chk("stall_npc", u_next_pc, 32'd77);
      chk("stall_link_we", {31'd0, u_link_we}, 32'd0);
      chk("stall_ras_empty", {31'd0, u_ras_empty}, {31'd0, ras_m.size() == 0});
    end
    out_ready = 1'b1;
    issue(32'd23, 32'd60, 32'd300, 32'd0, 32'd0);
    @(posedge clk); #1;
    chk("stall_no_dup", {31'd0, u_out_valid}, 32'd0);

    // reset discards a stalled jal result
    issue(32'd23, 32'd8, 32'd90, 32'd0, 32'd0);
    out_ready = 1'b0;
    @(posedge clk); #1;
    chk("rst_stall_hold", {31'd0, u_link_we}, 32'd1);
    reset = 1'b1; in_valid = 1'b1; instr_ID = 32'd23;
    #1;
    chk("rst_in_ready_hi", {31'd0, u_in_ready}, 32'd1);
    @(posedge clk); #1;
    chk("rst_kill_valid", {31'd0, u_out_valid}, 32'd0);
    chk("rst_kill_empty", {31'd0, u_ras_empty}, 32'd1);
    chk("rst_kill_link_we", {31'd0, u_link_we}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    ras_m.delete();
    @(posedge clk); #1;
    chk("rst_no_accept", {31'd0, u_out_valid}, 32'd0);
    chk("rst_still_empty", {31'd0, u_ras_empty}, 32'd1);

    // randomized traffic against the model
    for (int n = 0; n < 200; n++) begin
      id  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 31)) : 32'($urandom_range(15, 23));
      a   = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 8)) : $urandom;
      b   = ($urandom_range(0, 3) == 0) ? a : (($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 8)) : $urandom);
      p   = $urandom;
      off = $urandom;
      if (id == 32'd22 && ras_m.size() > 0 && $urandom_range(0, 1) == 1) a = ras_m[$];
      issue(id, p, a, b, off);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
